// File: rtl/pong_pkg.sv
// Shared definitions for the match countdown: controller states, 7-segment
// glyphs (active-low, bit order gfedcba) and prescaler sizing.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [6:0] SEG_DIG0  = 7'b1000000;
    localparam logic [6:0] SEG_DIG1  = 7'b1111001;
    localparam logic [6:0] SEG_DIG2  = 7'b0100100;
    localparam logic [6:0] SEG_DIG3  = 7'b0110000;
    localparam logic [6:0] SEG_DIG4  = 7'b0011001;
    localparam logic [6:0] SEG_DIG5  = 7'b0010010;
    localparam logic [6:0] SEG_DIG6  = 7'b0000010;
    localparam logic [6:0] SEG_DIG7  = 7'b1111000;
    localparam logic [6:0] SEG_DIG8  = 7'b0000000;
    localparam logic [6:0] SEG_DIG9  = 7'b0011000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BCD_ZERO = 4'd0;
    localparam logic [3:0] BCD_ONE  = 4'd1;
    localparam logic [3:0] BCD_NINE = 4'd9;

    // A 1 Hz "clock" still needs one prescaler bit to keep widths legal.
    function automatic int presc_width(input int hz);
        return (hz > 1) ? $clog2(hz) : 1;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Purely combinational BCD digit to active-low 7-segment pattern.
module seg7_decode
    import pong_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_DIG0;
            4'd1:    o_seg = SEG_DIG1;
            4'd2:    o_seg = SEG_DIG2;
            4'd3:    o_seg = SEG_DIG3;
            4'd4:    o_seg = SEG_DIG4;
            4'd5:    o_seg = SEG_DIG5;
            4'd6:    o_seg = SEG_DIG6;
            4'd7:    o_seg = SEG_DIG7;
            4'd8:    o_seg = SEG_DIG8;
            4'd9:    o_seg = SEG_DIG9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/match_countdown.sv
// Two-digit BCD match clock: counts START_SECS down to 00 at one step per
// CLK_HZ cycles, with pause/restart control and a one-cycle expiry pulse.
module match_countdown
    import pong_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int START_SECS = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    output logic [6:0] seg_left,
    output logic [6:0] seg_right,
    output logic       running,
    output logic       time_up
);

    localparam int              PS_W       = presc_width(CLK_HZ);
    localparam logic [PS_W-1:0] PS_LAST    = PS_W'(CLK_HZ - 1);
    localparam logic [3:0]      START_TENS = 4'(START_SECS / 10);
    localparam logic [3:0]      START_ONES = 4'(START_SECS % 10);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PS_W-1:0] r_presc;
    logic [PS_W-1:0] w_presc_nxt;
    logic [3:0]      r_tens;
    logic [3:0]      r_ones;
    logic [3:0]      w_tens_nxt;
    logic [3:0]      w_ones_nxt;
    logic            r_time_up;
    logic            w_time_up_nxt;
    logic            w_counting;
    logic            w_tick;
    logic            w_last_sec;

    // PAUSED with pause released counts on that same edge, so a pause of N
    // cycles delays the display by exactly N cycles.
    assign w_counting = ((r_state == ST_RUN) || (r_state == ST_PAUSED)) && !pause;
    assign w_tick     = w_counting && (r_presc == PS_LAST);
    assign w_last_sec = (r_tens == BCD_ZERO) && (r_ones == BCD_ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_tens    <= START_TENS;
            r_ones    <= START_ONES;
            r_time_up <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_tens    <= w_tens_nxt;
            r_ones    <= w_ones_nxt;
            r_time_up <= w_time_up_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_presc_nxt   = r_presc;
        w_tens_nxt    = r_tens;
        w_ones_nxt    = r_ones;
        w_time_up_nxt = 1'b0;

        // start reloads from any state and beats both pause and a pending tick
        if (start) begin
            w_state_nxt = ST_RUN;
            w_presc_nxt = '0;
            w_tens_nxt  = START_TENS;
            w_ones_nxt  = START_ONES;
        end else begin
            case (r_state)
                ST_RUN, ST_PAUSED: begin
                    if (pause) begin
                        w_state_nxt = ST_PAUSED;
                    end else if (w_tick) begin
                        w_presc_nxt = '0;
                        if (r_ones != BCD_ZERO) begin
                            w_ones_nxt = r_ones - 4'd1;
                        end else begin
                            w_ones_nxt = BCD_NINE;
                            w_tens_nxt = r_tens - 4'd1;
                        end
                        if (w_last_sec) begin
                            w_state_nxt   = ST_EXPIRED;
                            w_time_up_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_RUN;
                        end
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_presc_nxt = r_presc + PS_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    assign running = (r_state == ST_RUN);
    assign time_up = r_time_up;

    seg7_decode u_seg_left (
        .i_bcd (r_tens),
        .o_seg (seg_left)
    );

    seg7_decode u_seg_right (
        .i_bcd (r_ones),
        .o_seg (seg_right)
    );

endmodule

// File: doc/match_countdown.md
MATCH_COUNTDOWN -- requirements
Module: match_countdown

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000: clk cycles per displayed second.
REQ-002 SHALL have parameter START_SECS, default 60: countdown start value in seconds; legal range 1..99.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle pulse that loads START_SECS and begins or restarts the countdown.
REQ-006 SHALL have port pause, input, 1 bit: level; while high, the countdown freezes.
REQ-007 SHALL have port seg_left, output, 7 bits: active-low 7-segment pattern for the tens digit.
REQ-008 SHALL have port seg_right, output, 7 bits: active-low 7-segment pattern for the ones digit.
REQ-009 SHALL have port running, output, 1 bit: high only in state RUN.
REQ-010 SHALL have port time_up, output, 1 bit: registered single-cycle pulse on expiry.

Function
REQ-011 SHALL implement the states IDLE, RUN, PAUSED and EXPIRED.
REQ-012 SHALL hold the time as two BCD registers, tens (0..9) and ones (0..9), which are never binary.
REQ-013 SHALL run a prescaler counting 0..CLK_HZ-1 in RUN only; tick = prescaler at CLK_HZ-1 and not pause; the prescaler wraps to 0 on tick.
REQ-014 SHALL decrement on tick: ones-1 if ones != 0, else ones=9 and tens-1.
REQ-015 SHALL, on the tick that yields 00, enter EXPIRED and assert time_up for exactly one clk cycle, coincident with the display changing to 00.
REQ-016 SHALL never decrement in EXPIRED, IDLE or PAUSED; there is no wrap below 00.
REQ-017 SHALL, in IDLE, move to RUN on start, with the prescaler cleared.
REQ-018 SHALL, in RUN, move to PAUSED when pause=1 and start=0; the prescaler holds its value.
REQ-019 SHALL, in PAUSED, return to RUN when pause=0; the prescaler resumes from its held value, so the elapsed partial second is kept.
REQ-020 SHALL treat start in any state as a reload: tens/ones=START_SECS, prescaler=0, state RUN, time_up=0.
REQ-021 SHALL give start priority over pause in the same cycle; pause still high on the next cycle then enters PAUSED.
REQ-022 SHALL give start priority over a coincident tick: the reload wins, with no decrement and no time_up.
REQ-023 SHALL, when pause rises in the same cycle as a would-be tick, suppress that tick and enter PAUSED.
REQ-024 SHALL drive seg_left/seg_right combinationally from tens/ones: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000; any non-BCD value gives 1111111.
REQ-025 SHALL size the prescaler as ceil(log2(CLK_HZ)) bits.

Reset
REQ-026 SHALL, while reset=1 (asynchronously, without waiting for clk), force state=IDLE, tens/ones=START_SECS, prescaler=0, running=0 and time_up=0.
REQ-027 SHALL show START_SECS on seg outputs during and after reset (defaults give seg_left=0000010, seg_right=1000000).
REQ-028 SHALL, when reset is asserted mid-RUN or mid-PAUSED, abandon the count with no time_up.

Structure
REQ-029 SHALL place the digit-to-segment constants, the blank pattern and the state enumeration in the shared package pong_pkg.
REQ-030 SHALL instantiate the sub-module seg7_decode, a purely combinational BCD-to-7-segment decoder, twice.

Verification (CLK_HZ=4, START_SECS=12)
REQ-031 Reset -> seg_left=1111001, seg_right=0100100, running=0, time_up=0; holds indefinitely without start.
REQ-032 Start pulse -> running=1; display 11 after 4 cycles, 10 after 8, 09 after 12 (borrow), 08 after 16.
REQ-033 Start, free run -> time_up high for exactly 1 cycle 48 cycles after start, display 00, running=0; no change for 100 more cycles.
REQ-034 Start, pause high for 10 cycles at cycle 2 -> 11 appears at cycle 14, expiry at cycle 58.
REQ-035 Start at display 07 -> display 12 on the next cycle, then 11 exactly 4 cycles later; start plus pause together -> RUN for one cycle, then PAUSED.
REQ-036 Reset pulsed mid-run at display 05 -> immediately 12, IDLE, time_up never asserted; start in EXPIRED -> reloads 12 and counts.
